// File: rtl/otter_hazard_ctrl.sv
// Hazard, forwarding and pipeline-control unit for the pipelined OTTER core.
// A scoreboard shift register mirrors every in-flight instruction behind decode.
module otter_hazard_ctrl #(
  parameter int NUM_STAGES = 3,
  parameter int LOAD_READY = 3,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_rs1_used,
  input  logic             dec_rs2_used,
  input  logic [4:0]       dec_rd,
  input  logic             dec_reg_write,
  input  logic             dec_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             dec_hold,
  output logic             ex_bubble,
  output logic             if_flush,
  output logic [SEL_W-1:0] ex_fwd_a_sel,
  output logic [SEL_W-1:0] ex_fwd_b_sel,
  output logic             dec_bypass_a,
  output logic             dec_bypass_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;       // writes a real register (rd != x0)
    logic       load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
  } entry_t;

  entry_t sb [1:NUM_STAGES];
  entry_t dec_entry;
  logic   load_use;
  logic   flush;
  logic   stall_event;

  // True when entry e will write register s that the consumer actually reads.
  function automatic logic produces(input entry_t e, input logic [4:0] s, input logic used);
    return e.valid & e.wr & (e.rd == s) & used;
  endfunction

  always_comb begin
    dec_entry          = '0;
    dec_entry.valid    = 1'b1;
    dec_entry.rd       = dec_rd;
    dec_entry.wr       = dec_reg_write & (dec_rd != 5'd0);
    dec_entry.load     = dec_is_load;
    dec_entry.rs1      = dec_rs1;
    dec_entry.rs2      = dec_rs2;
    dec_entry.rs1_used = dec_rs1_used;
    dec_entry.rs2_used = dec_rs2_used;
  end

  // Only loads too young to have data at LOAD_READY stall decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    load_use = 1'b0;
    for (int p = 1; p <= LOAD_READY - 2; p++) begin
      if (sb[p].load && (produces(sb[p], dec_rs1, dec_rs1_used) ||
                         produces(sb[p], dec_rs2, dec_rs2_used)))
        load_use = 1'b1;
    end
    load_use = load_use & dec_valid;
  end

  assign flush       = ex_branch_taken & sb[1].valid;
  assign if_flush    = flush & ~mem_busy;
  assign ex_bubble   = (flush | load_use) & ~mem_busy;
  assign dec_hold    = mem_busy | (load_use & ~flush);
  assign pc_write    = ~dec_hold;
  assign stall_event = load_use & ~flush & ~mem_busy;

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    ex_fwd_a_sel = '0;
    ex_fwd_b_sel = '0;
    for (int p = NUM_STAGES; p >= 2; p--) begin
      if (produces(sb[p], sb[1].rs1, sb[1].rs1_used)) ex_fwd_a_sel = SEL_W'(p);
      if (produces(sb[p], sb[1].rs2, sb[1].rs2_used)) ex_fwd_b_sel = SEL_W'(p);
    end
    if (!sb[1].valid) begin
      ex_fwd_a_sel = '0;
      ex_fwd_b_sel = '0;
    end
  end

  // The last stage writes the register file in the same cycle decode reads it.
  assign dec_bypass_a = dec_valid & produces(sb[NUM_STAGES], dec_rs1, dec_rs1_used);
  assign dec_bypass_b = dec_valid & produces(sb[NUM_STAGES], dec_rs2, dec_rs2_used);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the scoreboard is a handful of flops, not a RAM, so every entry is reset.
      for (int k = 1; k <= NUM_STAGES; k++) sb[k] <= '0;
    end else if (!mem_busy) begin
      // NOTE: non-blocking assignments make the shift read the pre-edge values of every entry.
      for (int k = NUM_STAGES; k >= 2; k--) sb[k] <= sb[k-1];
      sb[1] <= (flush || load_use || !dec_valid) ? entry_t'('0) : dec_entry;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_event && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (if_flush && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed bench for otter_hazard_ctrl: a per-cycle vector table plus hand-written
// sequences for counter saturation and asynchronous reset during a stall.
module tb_otter_hazard_ctrl;

  logic       CLK;
  logic       RESET_N;
  logic       dec_valid;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_rs1_used, dec_rs2_used, dec_reg_write, dec_is_load;
  logic       ex_branch_taken, mem_busy;

  logic        pc_write, dec_hold, ex_bubble, if_flush;
  logic [1:0]  ex_fwd_a_sel, ex_fwd_b_sel;
  logic        dec_bypass_a, dec_bypass_b;
  logic [31:0] stall_count, flush_count;

  logic        s_pc_write, s_dec_hold, s_ex_bubble, s_if_flush;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic        s_byp_a, s_byp_b;
  logic [1:0]  s_stall_count, s_flush_count;

  int n_cmp  = 0;
  int n_fail = 0;

  otter_hazard_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_reg_write(dec_reg_write), .dec_is_load(dec_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .dec_hold(dec_hold), .ex_bubble(ex_bubble), .if_flush(if_flush),
    .ex_fwd_a_sel(ex_fwd_a_sel), .ex_fwd_b_sel(ex_fwd_b_sel),
    .dec_bypass_a(dec_bypass_a), .dec_bypass_b(dec_bypass_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow-counter copy on the same stimulus, used to reach saturation quickly.
  otter_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .CLK(CLK), .RESET_N(RESET_N), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_reg_write(dec_reg_write), .dec_is_load(dec_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(s_pc_write), .dec_hold(s_dec_hold), .ex_bubble(s_ex_bubble), .if_flush(s_if_flush),
    .ex_fwd_a_sel(s_fwd_a), .ex_fwd_b_sel(s_fwd_b),
    .dec_bypass_a(s_byp_a), .dec_bypass_b(s_byp_b),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int dv, rs1, rs2, u1, u2, rd, rw, ld, br, busy;   // decode/control inputs
    int pc, hold, bub, fl, sa, sb, ba, bb, sc, fc;     // expected outputs this cycle
  } vec_t;

  vec_t vecs [25];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int dv, rs1, rs2, u1, u2, rd, rw, ld, br, busy);
    dec_valid       = 1'(dv);
    dec_rs1         = 5'(rs1);
    dec_rs2         = 5'(rs2);
    dec_rs1_used    = 1'(u1);
    dec_rs2_used    = 1'(u2);
    dec_rd          = 5'(rd);
    dec_reg_write   = 1'(rw);
    dec_is_load     = 1'(ld);
    ex_branch_taken = 1'(br);
    mem_busy        = 1'(busy);
  endtask

  task automatic check_outs(input string tag, input int pc, hold, bub, fl, sa, sb, ba, bb, sc, fc);
    check({tag, " pc_write"},     64'(pc_write),     64'(pc));
    check({tag, " dec_hold"},     64'(dec_hold),     64'(hold));
    check({tag, " ex_bubble"},    64'(ex_bubble),    64'(bub));
    check({tag, " if_flush"},     64'(if_flush),     64'(fl));
    check({tag, " ex_fwd_a_sel"}, 64'(ex_fwd_a_sel), 64'(sa));
    check({tag, " ex_fwd_b_sel"}, 64'(ex_fwd_b_sel), 64'(sb));
    check({tag, " dec_bypass_a"}, 64'(dec_bypass_a), 64'(ba));
    check({tag, " dec_bypass_b"}, 64'(dec_bypass_b), 64'(bb));
    check({tag, " stall_count"},  64'(stall_count),  64'(sc));
    check({tag, " flush_count"},  64'(flush_count),  64'(fc));
  endtask

  initial begin
    //           dv rs1 rs2 u1 u2 rd rw ld br bz | pc hd bb fl sa sb ba bb sc fc
    vecs[0]  = '{1, 2, 0, 1, 0, 5, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // lw x5
    vecs[1]  = '{1, 5, 1, 1, 1, 6, 1, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0}; // add x6,x5,x1 stalls
    vecs[2]  = '{1, 5, 1, 1, 1, 6, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // retry proceeds
    vecs[3]  = '{1, 1, 2, 1, 1, 3, 1, 0, 0, 0,  1, 0, 0, 0, 3, 0, 0, 0, 1, 0}; // add x6 gets lw from stage 3
    vecs[4]  = '{1, 3, 3, 1, 1, 4, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // sub x4,x3,x3
    vecs[5]  = '{1, 1, 2, 1, 1, 8, 1, 0, 0, 0,  1, 0, 0, 0, 2, 2, 0, 0, 1, 0}; // sub forwards add x3 from 2
    vecs[6]  = '{1, 3, 4, 1, 1, 9, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 1, 0}; // decode reads x3 being written back
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3, 0, 0, 1, 0}; // and x9 gets x4 from stage 3
    vecs[8]  = '{1, 1, 2, 1, 1, 7, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // add x7 (a)
    vecs[9]  = '{1, 1, 2, 1, 1, 7, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // add x7 (b)
    vecs[10] = '{1, 7, 7, 1, 1, 10, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // add x10,x7,x7
    vecs[11] = '{1, 1, 2, 1, 1, 0, 1, 0, 0, 0,  1, 0, 0, 0, 2, 2, 0, 0, 1, 0}; // youngest x7 wins; write x0
    vecs[12] = '{1, 0, 0, 1, 1, 11, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // add x11,x0,x0
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // x0 never forwards
    vecs[14] = '{1, 2, 0, 0, 0, 5, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0}; // lw x5
    vecs[15] = '{1, 5, 1, 1, 1, 6, 1, 0, 1, 0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 0}; // branch over load_use
    vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 1}; // only flush counted
    vecs[17] = '{1, 1, 2, 1, 1, 13, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1}; // add x13
    vecs[18] = '{1, 13, 0, 1, 0, 12, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1}; // lw x12,(x13)
    vecs[19] = '{1, 12, 12, 1, 1, 14, 1, 0, 1, 1, 0, 1, 0, 0, 2, 0, 0, 0, 1, 1}; // busy 1: all frozen
    vecs[20] = '{1, 12, 12, 1, 1, 14, 1, 0, 1, 1, 0, 1, 0, 0, 2, 0, 0, 0, 1, 1}; // busy 2
    vecs[21] = '{1, 12, 12, 1, 1, 14, 1, 0, 1, 1, 0, 1, 0, 0, 2, 0, 0, 0, 1, 1}; // busy 3
    vecs[22] = '{1, 12, 12, 1, 1, 14, 1, 0, 1, 1, 0, 1, 0, 0, 2, 0, 0, 0, 1, 1}; // busy 4
    vecs[23] = '{1, 12, 12, 1, 1, 14, 1, 0, 1, 0, 1, 0, 1, 1, 2, 0, 0, 0, 1, 1}; // deferred flush fires
    vecs[24] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 2}; // flush counted

    // Reset state.
    RESET_N = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check_outs("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Table: drive at negedge, sample 2 time units later, then the posedge commits.
    for (int i = 0; i < 25; i++) begin
      @(negedge CLK);
      drive(vecs[i].dv, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
            vecs[i].rd, vecs[i].rw, vecs[i].ld, vecs[i].br, vecs[i].busy);
      #2;
      check_outs($sformatf("v%0d", i), vecs[i].pc, vecs[i].hold, vecs[i].bub, vecs[i].fl,
                 vecs[i].sa, vecs[i].sb, vecs[i].ba, vecs[i].bb, vecs[i].sc, vecs[i].fc);
    end

    // Four more flushes: wide counter reaches 6, 2-bit counter saturates at 3.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      drive(1, 0, 0, 0, 0, 15, 1, 0, 0, 0);
      @(negedge CLK);
      drive(1, 0, 0, 0, 0, 15, 1, 0, 1, 0);
      #2;
      check($sformatf("sat flush %0d if_flush", i), 64'(if_flush), 64'd1);
    end
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("sat flush_count wide",   64'(flush_count),   64'd6);
    check("sat flush_count narrow", 64'(s_flush_count), 64'd3);
    check("sat stall_count narrow", 64'(s_stall_count), 64'd1);

    // Three more load-use stalls: wide stall counter reaches 4, narrow sticks at 3.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
      @(negedge CLK);
      drive(1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
      #2;
      check($sformatf("sat stall %0d pc_write", i), 64'(pc_write), 64'd0);
      @(negedge CLK);
      #2;
      check($sformatf("sat stall %0d release", i), 64'(pc_write), 64'd1);
    end
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("sat stall_count wide",   64'(stall_count),   64'd4);
    check("sat stall_count narrow", 64'(s_stall_count), 64'd3);
    check("sat flush_count hold",   64'(flush_count),   64'd6);

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge CLK);
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    @(negedge CLK);
    drive(1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
    #2;
    check("pre-reset dec_hold", 64'(dec_hold), 64'd1);
    #1 RESET_N = 1'b0;
    #1;
    check_outs("async reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("async reset narrow stall", 64'(s_stall_count), 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    #2;
    check("post-reset pc_write", 64'(pc_write), 64'd1);
    @(negedge CLK);
    drive(1, 5, 0, 1, 0, 6, 1, 0, 0, 0);
    #2;
    check_outs("post-reset stall", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    check("post-reset stall_count", 64'(stall_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
